// File: rtl/frogger_pkg.sv
// Shared game definitions: FSM encoding, lane count and per-lane base car-speed dividers.
// Also used by the car-position datapath, so keep lane order stable.
package frogger_pkg;

  localparam int FROGGER_NUM_LANES = 6;
  localparam int DIV_W             = 24;
  localparam logic [DIV_W-1:0] DIV_ONE = 24'd1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    PAUSE    = 3'd2,
    HIT      = 3'd3,
    LEVEL_UP = 3'd4,
    GAMEOVER = 3'd5
  } state_t;

  // Element [0] is the rightmost entry.
  localparam logic [FROGGER_NUM_LANES-1:0][DIV_W-1:0] LANE_BASE_DIV = {
    24'd120000, 24'd200000, 24'd100000, 24'd150000, 24'd100000, 24'd50000
  };

endpackage

// File: rtl/lane_divider.sv
// One lane's car-speed divider: counts run cycles and emits a registered one-cycle
// step every div cycles; clear zeroes the count, deasserted run holds it.
module lane_divider
  import frogger_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             step
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;

  always_comb begin
    cnt_d  = cnt_q;
    step_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      if (cnt_q >= div - DIV_ONE) begin
        step_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + DIV_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/traffic_scheduler.sv
// Frogger game FSM plus per-lane car step strobes. Define TRAFFIC_LEVEL_RAMP_EN to make
// lane dividers shrink with level (floored at MIN_DIV); otherwise dividers stay at base.
module traffic_scheduler
  import frogger_pkg::*;
#(
  parameter int                               NUM_LANES     = FROGGER_NUM_LANES,
  parameter logic [DIV_W-1:0]                 LEVEL_STEP    = 24'd10000,
  parameter logic [DIV_W-1:0]                 MIN_DIV       = 24'd20000,
  parameter logic [DIV_W-1:0]                 FREEZE_CYCLES = 24'd12500000,
  parameter int                               START_LIVES   = 3,
  parameter logic [NUM_LANES-1:0][DIV_W-1:0]  LANE_DIV      = LANE_BASE_DIV
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 pause_toggle,
  input  logic                 collision,
  input  logic                 goal,
  output logic [NUM_LANES-1:0] lane_step,
  output logic [3:0]           level,
  output logic [1:0]           lives,
  output logic [2:0]           state
);

  state_t           state_q, state_d;
  logic [3:0]       level_q, level_d;
  logic [1:0]       lives_q, lives_d;
  logic [DIV_W-1:0] freeze_q, freeze_d;
  logic             run_en, clr_en;
  logic [NUM_LANES-1:0][DIV_W-1:0] eff_div;

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    lives_d  = lives_q;
    freeze_d = freeze_q;
    case (state_q)
      IDLE, GAMEOVER: begin
        if (start) begin
          state_d = RUN;
          lives_d = 2'(START_LIVES);
          level_d = 4'd0;
        end
      end
      RUN: begin
        if (collision) begin
          if (lives_q > 2'd1) begin
            state_d  = HIT;
            lives_d  = lives_q - 2'd1;
            freeze_d = '0;
          end else begin
            state_d = GAMEOVER;
            lives_d = 2'd0;
          end
        end else if (goal) begin
          state_d = LEVEL_UP;
          if (level_q != 4'd15) level_d = level_q + 4'd1;
        end else if (pause_toggle) begin
          state_d = PAUSE;
        end
      end
      PAUSE: if (pause_toggle) state_d = RUN;
      HIT: begin
        if (freeze_q >= FREEZE_CYCLES - DIV_ONE) begin
          state_d  = RUN;
          freeze_d = '0;
        end else begin
          freeze_d = freeze_q + DIV_ONE;
        end
      end
      LEVEL_UP: state_d = RUN;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      level_q  <= 4'd0;
      lives_q  <= 2'd0;
      freeze_q <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      lives_q  <= lives_d;
      freeze_q <= freeze_d;
    end
  end

  // Counters advance only on cycles that stay in RUN, so the registered strobe never
  // lands in a non-RUN state; every state other than RUN/PAUSE keeps them cleared.
  assign run_en = (state_q == RUN) && (state_d == RUN);
  assign clr_en = !((state_q == RUN) || (state_q == PAUSE));

`ifdef TRAFFIC_LEVEL_RAMP_EN
  logic [NUM_LANES-1:0][DIV_W-1:0] eff_div_q, eff_div_d;
  logic game_start;

  function automatic logic [DIV_W-1:0] ramp_div(input logic [DIV_W-1:0] base,
                                                input logic [3:0]       lvl);
    logic [DIV_W+3:0] dec;
    logic [DIV_W-1:0] diff;
    dec = {{DIV_W{1'b0}}, lvl} * {4'd0, LEVEL_STEP};
    if (dec >= {4'd0, base}) begin
      ramp_div = MIN_DIV;
    end else begin
      diff     = base - dec[DIV_W-1:0];
      ramp_div = (diff < MIN_DIV) ? MIN_DIV : diff;
    end
  endfunction

  assign game_start = start && ((state_q == IDLE) || (state_q == GAMEOVER));

  always_comb begin
    eff_div_d = eff_div_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (game_start)                 eff_div_d[i] = ramp_div(LANE_DIV[i], 4'd0);
      else if (state_q == LEVEL_UP)   eff_div_d[i] = ramp_div(LANE_DIV[i], level_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) eff_div_q <= LANE_DIV;
    else       eff_div_q <= eff_div_d;
  end

  assign eff_div = eff_div_q;
`else
  assign eff_div = LANE_DIV;
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_divider u_lane_divider (
      .clk   (clk),
      .reset (reset),
      .run   (run_en),
      .clear (clr_en),
      .div   (eff_div[i]),
      .step  (lane_step[i])
    );
  end

  assign level = level_q;
  assign lives = lives_q;
  assign state = state_q;

endmodule

// File: tb/tb_traffic_scheduler.sv
// Bench for traffic_scheduler with small dividers; a cycle-level game model built on
// per-lane run-cycle totals (modulo divider) predicts every output.
module tb_traffic_scheduler;
  import frogger_pkg::*;

  logic       clk, reset, start, pause_toggle, collision, goal;
  logic [5:0] lane_step;
  logic [3:0] level;
  logic [1:0] lives;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  int base_div [6] = '{4, 5, 3, 5, 6, 7};

  traffic_scheduler #(
    .NUM_LANES     (6),
    .LEVEL_STEP    (24'd1),
    .MIN_DIV       (24'd2),
    .FREEZE_CYCLES (24'd3),
    .START_LIVES   (3),
    .LANE_DIV      ({24'd7, 24'd6, 24'd5, 24'd3, 24'd5, 24'd4})
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pause_toggle (pause_toggle),
    .collision    (collision),
    .goal         (goal),
    .lane_step    (lane_step),
    .level        (level),
    .lives        (lives),
    .state        (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: game rules, with lane strobes derived from total run cycles.
  state_t     m_st;
  int         m_lives, m_level, m_freeze;
  int         m_cnt [6];
  logic [5:0] m_step;

  function automatic int m_div(int i, int lvl);
    int d;
    d = base_div[i];
`ifdef TRAFFIC_LEVEL_RAMP_EN
    d = d - lvl;
    if (d < 2) d = 2;
`endif
    return d;
  endfunction

  always @(posedge clk) begin
    m_step = '0;
    if (reset) begin
      m_st = IDLE; m_lives = 0; m_level = 0; m_freeze = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else begin
      case (m_st)
        IDLE, GAMEOVER: if (start) begin
          m_st = RUN; m_lives = 3; m_level = 0;
          foreach (m_cnt[i]) m_cnt[i] = 0;
        end
        RUN: begin
          if (collision) begin
            if (m_lives > 1) begin m_lives--; m_st = HIT; m_freeze = 0; end
            else begin m_lives = 0; m_st = GAMEOVER; end
          end else if (goal) begin
            if (m_level < 15) m_level++;
            m_st = LEVEL_UP;
          end else if (pause_toggle) begin
            m_st = PAUSE;
          end else begin
            foreach (m_cnt[i]) begin
              m_cnt[i]++;
              if (m_cnt[i] % m_div(i, m_level) == 0) m_step[i] = 1'b1;
            end
          end
        end
        PAUSE: if (pause_toggle) m_st = RUN;
        HIT: begin
          m_freeze++;
          if (m_freeze == 3) m_st = RUN;
          foreach (m_cnt[i]) m_cnt[i] = 0;
        end
        LEVEL_UP: begin
          m_st = RUN;
          foreach (m_cnt[i]) m_cnt[i] = 0;
        end
        default: m_st = IDLE;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; pause_toggle = 1'b0; collision = 1'b0; goal = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic do_start();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; pause_toggle = 1'b1; collision = 1'b1; goal = 1'b1;
    tick(); tick();
    checks++;
    if ({state, level, lives, lane_step} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", {state, level, lives, lane_step});
    end
    reset = 1'b0; start = 1'b0; pause_toggle = 1'b0; collision = 1'b0; goal = 1'b0;
    tick();
    checks++;
    if (state !== IDLE) begin
      failures++; $display("FAIL post_reset_idle: got %0d expected %0d", state, IDLE);
    end
  endtask

  task automatic test_start_period();
    do_start();
    checks++;
    if ({state, lives, level} !== {RUN, 2'd3, 4'd0}) begin
      failures++;
      $display("FAIL start_to_run: got st=%0d lives=%0d lvl=%0d expected 1/3/0", state, lives, level);
    end
    for (int c = 1; c <= 16; c++) begin
      tick();
      checks++;
      if (lane_step[0] !== (c % 4 == 0)) begin
        failures++; $display("FAIL lane0_period c=%0d: got %b expected %b", c, lane_step[0], (c % 4 == 0));
      end
      checks++;
      if (lane_step !== m_step) begin
        failures++; $display("FAIL lanes_run c=%0d: got %b expected %b", c, lane_step, m_step);
      end
    end
  endtask

  task automatic test_pause();
    do_start();
    tick(); tick();
    pause_toggle = 1'b1; tick(); pause_toggle = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({state, lane_step} !== {PAUSE, 6'd0}) begin
        failures++; $display("FAIL pause_hold c=%0d: got st=%0d step=%b expected 2/0", c, state, lane_step);
      end
      tick();
    end
    pause_toggle = 1'b1; tick(); pause_toggle = 1'b0;
    checks++;
    if ({state, lane_step[0]} !== {RUN, 1'b0}) begin
      failures++; $display("FAIL resume: got st=%0d step0=%b expected 1/0", state, lane_step[0]);
    end
    tick();
    checks++;
    if (lane_step[0] !== 1'b0) begin
      failures++; $display("FAIL resume_plus1: got %b expected 0", lane_step[0]);
    end
    tick();
    checks++;
    if (lane_step[0] !== 1'b1) begin
      failures++; $display("FAIL resume_plus2: got %b expected 1", lane_step[0]);
    end
    checks++;
    if (lane_step !== m_step) begin
      failures++; $display("FAIL resume_lanes: got %b expected %b", lane_step, m_step);
    end
  endtask

  task automatic test_levels();
    int t1, t2, exp_period;
    do_start();
    for (int g = 0; g < 3; g++) begin
      goal = 1'b1; tick(); goal = 1'b0;
      checks++;
      if (state !== LEVEL_UP) begin
        failures++; $display("FAIL level_up_state g=%0d: got %0d expected %0d", g, state, LEVEL_UP);
      end
      tick();
      checks++;
      if (state !== RUN) begin
        failures++; $display("FAIL level_up_return g=%0d: got %0d expected %0d", g, state, RUN);
      end
    end
    checks++;
    if (level !== 4'd3) begin
      failures++; $display("FAIL level3: got %0d expected 3", level);
    end
`ifdef TRAFFIC_LEVEL_RAMP_EN
    exp_period = 2;
`else
    exp_period = 4;
`endif
    t1 = -1; t2 = -1;
    for (int c = 1; c <= 30 && t2 < 0; c++) begin
      tick();
      checks++;
      if (lane_step !== m_step) begin
        failures++; $display("FAIL level3_lanes c=%0d: got %b expected %b", c, lane_step, m_step);
      end
      if (lane_step[0]) begin
        if (t1 < 0) t1 = c; else t2 = c;
      end
    end
    checks++;
    if (t2 < 0 || (t2 - t1) != exp_period) begin
      failures++; $display("FAIL level3_period: got %0d expected %0d", t2 - t1, exp_period);
    end
    for (int g = 0; g < 20; g++) begin
      goal = 1'b1; tick(); goal = 1'b0; tick();
    end
    checks++;
    if ({state, level} !== {RUN, 4'd15}) begin
      failures++; $display("FAIL level_saturate: got st=%0d lvl=%0d expected 1/15", state, level);
    end
  endtask

  task automatic test_collision();
    do_start();
    repeat (5) tick();
    for (int k = 0; k < 2; k++) begin
      collision = 1'b1; tick(); collision = 1'b0;
      for (int c = 0; c < 3; c++) begin
        checks++;
        if ({state, lives, lane_step} !== {HIT, 2'(2 - k), 6'd0}) begin
          failures++;
          $display("FAIL hit_freeze k=%0d c=%0d: got st=%0d lives=%0d step=%b expected 3/%0d/0",
                   k, c, state, lives, lane_step, 2 - k);
        end
        tick();
      end
      checks++;
      if (state !== RUN) begin
        failures++; $display("FAIL hit_return k=%0d: got %0d expected %0d", k, state, RUN);
      end
      for (int c = 1; c <= 4; c++) begin
        tick();
        checks++;
        if (lane_step[0] !== (c == 4)) begin
          failures++; $display("FAIL hit_cleared k=%0d c=%0d: got %b expected %b", k, c, lane_step[0], (c == 4));
        end
      end
    end
    collision = 1'b1; tick(); collision = 1'b0;
    checks++;
    if ({state, lives} !== {GAMEOVER, 2'd0}) begin
      failures++; $display("FAIL gameover: got st=%0d lives=%0d expected 5/0", state, lives);
    end
    goal = 1'b1; collision = 1'b1; pause_toggle = 1'b1; tick();
    goal = 1'b0; collision = 1'b0; pause_toggle = 1'b0; tick();
    checks++;
    if ({state, lives, level} !== {GAMEOVER, 2'd0, 4'd0}) begin
      failures++; $display("FAIL gameover_ignore: got st=%0d lives=%0d lvl=%0d expected 5/0/0", state, lives, level);
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if ({state, lives} !== {RUN, 2'd3}) begin
      failures++; $display("FAIL restart: got st=%0d lives=%0d expected 1/3", state, lives);
    end
  endtask

  task automatic test_simultaneous();
    do_start();
    tick();
    collision = 1'b1; goal = 1'b1; tick(); collision = 1'b0; goal = 1'b0;
    checks++;
    if ({state, level, lives} !== {HIT, 4'd0, 2'd2}) begin
      failures++; $display("FAIL coll_goal: got st=%0d lvl=%0d lives=%0d expected 3/0/2", state, level, lives);
    end
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if ({state, lives, lane_step} !== {IDLE, 2'd0, 6'd0}) begin
      failures++; $display("FAIL reset_mid_hit: got st=%0d lives=%0d expected 0/0", state, lives);
    end
    tick();
    checks++;
    if (state !== IDLE) begin
      failures++; $display("FAIL after_reset_hit: got %0d expected %0d", state, IDLE);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      start        = ($urandom_range(0, 7) == 0);
      pause_toggle = ($urandom_range(0, 11) == 0);
      collision    = ($urandom_range(0, 39) == 0);
      goal         = ($urandom_range(0, 19) == 0);
      reset        = ($urandom_range(0, 499) == 0);
      tick();
      checks++;
      if ({state, lives, level, lane_step} !== {m_st, 2'(m_lives), 4'(m_level), m_step}) begin
        failures++;
        $display("FAIL random c=%0d: got st=%0d lives=%0d lvl=%0d step=%b expected st=%0d lives=%0d lvl=%0d step=%b",
                 c, state, lives, level, lane_step, m_st, m_lives, m_level, m_step);
      end
    end
    reset = 1'b0; start = 1'b0; pause_toggle = 1'b0; collision = 1'b0; goal = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause_toggle = 1'b0; collision = 1'b0; goal = 1'b0;
    test_reset();
    test_start_period();
    test_pause();
    test_levels();
    test_collision();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_scheduler.md
TRAFFIC_SCHEDULER -- requirements
Module: traffic_scheduler

Interface
REQ-001 SHALL have parameter NUM_LANES, default 6, number of road lanes driven.
REQ-002 SHALL have parameter LEVEL_STEP, default 24'd10000, divider reduction per level.
REQ-003 SHALL have parameter MIN_DIV, default 24'd20000, floor on any effective lane divider.
REQ-004 SHALL have parameter FREEZE_CYCLES, default 24'd12500000, hold time after a collision.
REQ-005 SHALL have parameter START_LIVES, default 3, lives loaded on start.
REQ-006 clk  input  1  system clock.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  one-cycle pulse; begins a game from IDLE or GAMEOVER.
REQ-009 pause_toggle  input  1  one-cycle pulse; RUN<->PAUSE.
REQ-010 collision  input  1  one-cycle pulse; frog hit by car.
REQ-011 goal  input  1  one-cycle pulse; frog reached far bank.
REQ-012 lane_step  output  NUM_LANES  one-cycle per-lane "advance car 1 pixel" strobes.
REQ-013 level  output  4  current level, 0..15.
REQ-014 lives  output  2  remaining lives.
REQ-015 state  output  3  encoded FSM state (state_t).

Function
REQ-016 FSM states: IDLE, RUN, PAUSE, HIT, LEVEL_UP, GAMEOVER.
REQ-017 IDLE: start -> RUN; lives<=START_LIVES, level<=0, all lane counters cleared.
REQ-018 RUN: per lane, counter increments each cycle; when counter >= eff_div[i]-1, lane_step[i]=1 that cycle and counter<=0; period exactly eff_div[i] cycles.
REQ-019 lane_step SHALL be registered and zero in every state except RUN.
REQ-020 PAUSE: counters hold value; pause_toggle -> RUN, resuming without counter loss.
REQ-021 RUN collision: lives>1 -> HIT, lives decrement; lives==1 -> GAMEOVER, lives<=0.
REQ-022 HIT: freeze counter counts FREEZE_CYCLES cycles, then RUN with all lane counters cleared.
REQ-023 RUN goal -> LEVEL_UP for exactly one cycle; level increments, saturating at 15; then RUN with counters cleared.
REQ-024 eff_div[i] = max(LANE_BASE_DIV[i] - level*LEVEL_STEP, MIN_DIV), 24-bit unsigned, underflow-safe (compare before subtract); registered, updated in the LEVEL_UP cycle and on start.
REQ-025 Simultaneous events in RUN priority: collision > goal > pause_toggle; lower-priority pulses that cycle are dropped.
REQ-026 Inputs other than start ignored in IDLE and GAMEOVER; collision, goal, start ignored in PAUSE, HIT, LEVEL_UP.
REQ-027 GAMEOVER: level and lives held for display; start -> RUN as REQ-017.

Reset
REQ-028 reset SHALL override all inputs: state<=IDLE, lane_step<=0, level<=0, lives<=0, all counters and freeze counter <=0, eff_div<=LANE_BASE_DIV.
REQ-029 reset asserted mid-HIT or mid-PAUSE SHALL abandon the operation; first post-reset cycle is IDLE.

Configuration
REQ-030 Macro TRAFFIC_LEVEL_RAMP_EN defined: eff_div per REQ-024.
REQ-031 Macro undefined: eff_div[i] fixed at LANE_BASE_DIV[i]; level still counts and saturates; no multiply/compare logic synthesized.

Structure
REQ-032 Package frogger_pkg SHALL hold state_t, NUM_LANES default, LANE_BASE_DIV array (50000, 100000, 150000, 100000, 200000, 120000), shared with the car-position datapath.
REQ-033 One sub-module lane_divider (one counter, compare, strobe, hold/clear inputs) SHALL be instantiated NUM_LANES times via generate.

Verification (LANE_BASE_DIV[0]=4, LEVEL_STEP=1, MIN_DIV=2, FREEZE_CYCLES=3, START_LIVES=3)
REQ-034 reset, start -> RUN next cycle; lane_step[0] pulses every 4 cycles; all outputs 0 during reset.
REQ-035 RUN, pause_toggle at counter=2, wait 10, pause_toggle -> lane_step[0] fires 2 cycles after resume, none during PAUSE.
REQ-036 goal x3 -> level=3, lane0 period 2 (floored); goal x20 -> level saturates at 15.
REQ-037 collision -> lives 3->2, state HIT 3 cycles, no strobes, RUN with counters cleared; third collision -> GAMEOVER, lives=0.
REQ-038 collision and goal same cycle -> HIT, level unchanged; reset during HIT -> IDLE, lives=0.
